// File: rtl/therm_duty_ctrl_if.sv
// Configuration/status bundle between the PWM configuration side and the
// thermometer hold controller.
interface therm_duty_ctrl_if #(
    parameter int SEL_W = 3,
    parameter int H_W   = 5,
    parameter int LVL_W = 3
);
    logic             ena;
    logic [SEL_W-1:0] sel;
    logic             sel_load;
    logic             ramp_en;
    logic             tick;
    logic [H_W-1:0]   h;
    logic [LVL_W-1:0] level;
    logic             busy;
    logic             done;

    modport master (
        output ena, sel, sel_load, ramp_en, tick,
        input  h, level, busy, done
    );

    modport slave (
        input  ena, sel, sel_load, ramp_en, tick,
        output h, level, busy, done
    );
endinterface

// File: rtl/therm_duty_ctrl.sv
// Thermometer hold-word controller: latches a selector into a target level
// and walks the registered hold word toward it on PWM period boundaries,
// either in one jump (direct) or one level per period (ramp / soft-start).
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | level equals target, ticks leave level alone
// ST_UP   | level below target, tick raises level
// ST_DOWN | level above target, tick lowers level
module therm_duty_ctrl #(
    parameter int SEL_W = 3,
    parameter int H_W   = 5,
    parameter int LVL_W = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    therm_duty_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

    // Selector+1 is formed one bit wider so the all-ones selector cannot wrap.
    localparam logic [SEL_W:0]   H_MAX_S = (SEL_W+1)'(H_W);
    localparam logic [LVL_W-1:0] H_MAX_L = LVL_W'(H_W);
    localparam logic [LVL_W-1:0] ONE_L   = LVL_W'(1);

    state_t           state_q, state_d;
    logic [LVL_W-1:0] l_q, l_d;
    logic [LVL_W-1:0] t_q, t_d;
    logic [H_W-1:0]   h_q, h_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [SEL_W:0]   sel_p1;

    // Next-state: target capture, tick-driven level step, and status flags.
    // The tick step uses the old target; a same-cycle load only changes t_d.
    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        t_d     = t_q;
        h_d     = h_q;
        busy_d  = busy_q;
        done_d  = done_q;
        sel_p1  = {1'b0, bus.sel} + {{SEL_W{1'b0}}, 1'b1};

        if (bus.ena) begin
            if (bus.sel_load) begin
                t_d = (sel_p1 >= H_MAX_S) ? H_MAX_L : LVL_W'(sel_p1);
            end

            if (bus.tick) begin
                case (state_q)
                    ST_UP:   l_d = bus.ramp_en ? (l_q + ONE_L) : t_q;
                    ST_DOWN: l_d = bus.ramp_en ? (l_q - ONE_L) : t_q;
                    default: l_d = l_q;
                endcase
            end

            if (l_d < t_d) begin
                state_d = ST_UP;
            end else if (l_d > t_d) begin
                state_d = ST_DOWN;
            end else begin
                state_d = ST_IDLE;
            end

            busy_d = (l_d != t_d);
            // Only a tick landing on the target reports completion; a reload
            // that happens to match the current level just clears busy.
            done_d = bus.tick && (state_q != ST_IDLE) && (l_d == t_d);

            for (int i = 0; i < H_W; i++) begin
                h_d[i] = (i < int'(l_d));
            end
        end
    end

    // State registers; hold word is registered alongside the level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            l_q     <= '0;
            t_q     <= '0;
            h_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            t_q     <= t_d;
            h_q     <= h_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.h     = h_q;
    assign bus.level = l_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule
